// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types.
//   word_t      : 32-bit data/address word
//   ramstate_t  : RAM model handshake state (FREE/BUSY/ACCESS/ERROR)
//   arb_state_t : ram_arbiter FSM state
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;
endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first set bit of pend at or after ptr, wrapping mod NREQ.
//   pend  : pending vector
//   ptr   : starting index (must be < NREQ)
//   valid : any bit of pend set
//   idx   : chosen index
module rr_picker #(
  parameter int NREQ = 4,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] pend,
  input  logic [IW-1:0]   ptr,
  output logic            valid,
  output logic [IW-1:0]   idx
);
  // Scan farthest offset first so the nearest pending index is written last.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (pend[(int'(ptr) + k) % NREQ]) begin
        valid = 1'b1;
        idx   = IW'((int'(ptr) + k) % NREQ);
      end
    end
  end
endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one RAM port among NREQ cache requesters.
// One transaction at a time; grant held until RAM reports ACCESS.
// Optional LL/SC reservation tracking: define ARB_LLSC_EN.
//   CLK, nRST           : clock, async active-low reset
//   req_ren/wen/atomic  : per-requester request (wen wins; atomic = LL/SC)
//   req_addr/req_store  : per-requester address / write data
//   req_wait/req_load   : per-requester hold / read data or SC result
//   ramREN/WEN/addr/store, ramload, ramstate : RAM port
module ram_arbiter
  import cpu_types_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic [NREQ-1:0]      req_ren,
  input  logic [NREQ-1:0]      req_wen,
  input  logic [NREQ-1:0]      req_atomic,
  input  word_t [NREQ-1:0]     req_addr,
  input  word_t [NREQ-1:0]     req_store,
  output logic [NREQ-1:0]      req_wait,
  output word_t [NREQ-1:0]     req_load,
  output logic                 ramREN,
  output logic                 ramWEN,
  output word_t                ramaddr,
  output word_t                ramstore,
  input  word_t                ramload,
  input  ramstate_t            ramstate
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_t      state_q, state_d;
  logic [IW-1:0]   g_q, g_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]   g_next;
  logic [NREQ-1:0] pend;
  logic            pick_valid;
  logic [IW-1:0]   pick_idx;
  logic            g_sc;
`ifdef ARB_LLSC_EN
  logic [NREQ-1:0]       link_valid_q, link_valid_d;
  logic [NREQ-1:0][29:0] link_addr_q, link_addr_d;
  logic                  g_ll, g_linked;
`endif

  assign pend   = req_ren | req_wen;
  assign g_next = (g_q == IW'(NREQ - 1)) ? '0 : g_q + IW'(1);

  rr_picker #(.NREQ(NREQ), .IW(IW)) u_pick (
    .pend  (pend),
    .ptr   (rr_ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d  = state_q;
    g_d      = g_q;
    rr_ptr_d = rr_ptr_q;
    req_wait = pend;
    req_load = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    g_sc     = req_atomic[g_q] & req_wen[g_q];
`ifdef ARB_LLSC_EN
    link_valid_d = link_valid_q;
    link_addr_d  = link_addr_q;
    g_ll         = req_atomic[g_q] & req_ren[g_q] & ~req_wen[g_q];
    g_linked     = link_valid_q[g_q] & (link_addr_q[g_q] == req_addr[g_q][31:2]);
`endif
    case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          g_d     = pick_idx;
          state_d = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        if (!pend[g_q]) begin
          // Abort: requester withdrew; address/data still mirror it this cycle.
          ramaddr  = req_addr[g_q];
          ramstore = req_store[g_q];
          state_d  = ARB_IDLE;
          rr_ptr_d = g_next;
        end
`ifdef ARB_LLSC_EN
        else if (g_sc && !g_linked) begin
          // Failed SC never reaches RAM; it completes at once with result 0.
          req_wait[g_q]     = 1'b0;
          link_valid_d[g_q] = 1'b0;
          state_d           = ARB_IDLE;
          rr_ptr_d          = g_next;
        end
`endif
        else begin
          ramaddr  = req_addr[g_q];
          ramstore = req_store[g_q];
          ramWEN   = req_wen[g_q];
          ramREN   = req_ren[g_q] & ~req_wen[g_q];
          if (ramstate == ACCESS) begin
            req_wait[g_q] = 1'b0;
            req_load[g_q] = g_sc ? 32'd1 : ramload;
            state_d       = ARB_IDLE;
            rr_ptr_d      = g_next;
`ifdef ARB_LLSC_EN
            if (g_ll) begin
              link_valid_d[g_q] = 1'b1;
              link_addr_d[g_q]  = req_addr[g_q][31:2];
            end
            if (req_wen[g_q]) begin
              // A store kills every other reservation on the same word.
              for (int i = 0; i < NREQ; i++)
                if (i != int'(g_q) && link_addr_q[i] == req_addr[g_q][31:2])
                  link_valid_d[i] = 1'b0;
            end
            if (g_sc) link_valid_d[g_q] = 1'b0;
`endif
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= ARB_IDLE;
      g_q      <= '0;
      rr_ptr_q <= '0;
`ifdef ARB_LLSC_EN
      link_valid_q <= '0;
      link_addr_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      g_q      <= g_d;
      rr_ptr_q <= rr_ptr_d;
`ifdef ARB_LLSC_EN
      link_valid_q <= link_valid_d;
      link_addr_q  <= link_addr_d;
`endif
    end
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus a randomized
// phase, all checked against a transaction-level reference model.
module tb_ram_arbiter;
  import cpu_types_pkg::*;
  localparam int N = 4;
`ifdef ARB_LLSC_EN
  localparam bit LLSC = 1'b1;
`else
  localparam bit LLSC = 1'b0;
`endif

  logic CLK = 1'b0, nRST = 1'b0;
  logic [N-1:0] ren = '0, wen = '0, atomic = '0;
  word_t [N-1:0] addr = '0, store = '0;
  logic [N-1:0] req_wait;
  word_t [N-1:0] req_load;
  logic ramREN, ramWEN;
  word_t ramaddr, ramstore, ramload = '0;
  ramstate_t ramstate = FREE;

  always #5 CLK = ~CLK;

  ram_arbiter #(.NREQ(N)) dut (
    .CLK(CLK), .nRST(nRST), .req_ren(ren), .req_wen(wen), .req_atomic(atomic),
    .req_addr(addr), .req_store(store), .req_wait(req_wait), .req_load(req_load),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  int checks = 0, errors = 0;

  // Reference model: who owns the port, where the next search starts, reservations.
  int owner = -1, ptr = 0, n_owner, n_ptr;
  bit lv[N], n_lv[N];
  logic [29:0] la[N], n_la[N];
  logic [N-1:0] e_wait;
  word_t [N-1:0] e_load;
  logic e_ren, e_wen;
  word_t e_addr, e_store;
  // Observed values captured at the last check point.
  logic [N-1:0] o_wait;
  word_t [N-1:0] o_load;
  logic o_ren, o_wen;
  word_t o_addr, o_store;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    owner = -1; ptr = 0;
    for (int i = 0; i < N; i++) begin lv[i] = 0; la[i] = '0; end
  endtask

  task automatic model_eval();
    logic [N-1:0] pend;
    bit sc, ll, linked, done;
    int o;
    pend = ren | wen;
    e_wait = pend; e_load = '0; e_ren = 0; e_wen = 0; e_addr = '0; e_store = '0;
    n_owner = owner; n_ptr = ptr; n_lv = lv; n_la = la;
    if (owner < 0) begin
      for (int k = 0; k < N; k++)
        if (n_owner < 0 && pend[(ptr + k) % N]) n_owner = (ptr + k) % N;
    end else begin
      o = owner;
      sc = atomic[o] && wen[o];
      ll = atomic[o] && ren[o] && !wen[o];
      linked = lv[o] && (la[o] == addr[o][31:2]);
      done = 0;
      if (!pend[o]) begin
        e_addr = addr[o]; e_store = store[o]; done = 1;
      end else if (LLSC && sc && !linked) begin
        e_wait[o] = 0; n_lv[o] = 0; done = 1;
      end else begin
        e_addr = addr[o]; e_store = store[o];
        e_wen = wen[o]; e_ren = ren[o] && !wen[o];
        if (ramstate == ACCESS) begin
          e_wait[o] = 0;
          e_load[o] = sc ? 32'd1 : ramload;
          done = 1;
          if (LLSC) begin
            if (ll) begin n_lv[o] = 1; n_la[o] = addr[o][31:2]; end
            if (wen[o])
              for (int q = 0; q < N; q++)
                if (q != o && la[q] == addr[o][31:2]) n_lv[q] = 0;
            if (sc) n_lv[o] = 0;
          end
        end
      end
      if (done) begin n_owner = -1; n_ptr = (o + 1) % N; end
    end
  endtask

  // One clock: check outputs mid-cycle against the model, then advance it.
  task automatic step();
    @(negedge CLK);
    model_eval();
    chk("wait", 32'(req_wait), 32'(e_wait));
    for (int i = 0; i < N; i++) chk($sformatf("load%0d", i), req_load[i], e_load[i]);
    chk("ramREN", 32'(ramREN), 32'(e_ren));
    chk("ramWEN", 32'(ramWEN), 32'(e_wen));
    chk("ramaddr", ramaddr, e_addr);
    chk("ramstore", ramstore, e_store);
    o_wait = req_wait; o_load = req_load; o_ren = ramREN; o_wen = ramWEN;
    o_addr = ramaddr; o_store = ramstore;
    @(posedge CLK);
    if (nRST) begin owner = n_owner; ptr = n_ptr; lv = n_lv; la = n_la; end
    else model_reset();
    #1;
  endtask

  task automatic drain();
    ren = '0; wen = '0; atomic = '0;
    step(); step();
  endtask

  task automatic txn(input int i, input bit r, input bit w, input bit a,
                     input word_t ad, input word_t st,
                     output bit saw_wen, output word_t ld);
    bit done;
    ren[i] = r; wen[i] = w; atomic[i] = a; addr[i] = ad; store[i] = st;
    ramstate = ACCESS; ramload = $urandom;
    saw_wen = 0; done = 0; ld = '0;
    for (int c = 0; c < 8 && !done; c++) begin
      step();
      if (o_wen) saw_wen = 1;
      if (!o_wait[i]) begin done = 1; ld = o_load[i]; end
    end
    chk($sformatf("txn%0d_done", i), 32'(done), 32'd1);
    ren[i] = 0; wen[i] = 0; atomic[i] = 0;
  endtask

  initial begin
    int grants[$];
    bit act[N], saw;
    word_t ld;
    model_reset();
    #12;
    // Reset state
    chk("rst_ren", 32'(ramREN), 0);
    chk("rst_addr", ramaddr, 0);
    chk("rst_load", 32'(req_load[0] | req_load[1] | req_load[2] | req_load[3]), 0);
    nRST = 1'b1;
    @(posedge CLK); #1;

    // 1: read with BUSY,BUSY,ACCESS
    ren[1] = 1; addr[1] = 32'h40; ramstate = BUSY;
    step(); chk("t1_c1_ren", 32'(o_ren), 0);
    step(); chk("t1_c2_ren", 32'(o_ren), 1); chk("t1_c2_addr", o_addr, 32'h40);
    step(); chk("t1_c3_wait", 32'(o_wait[1]), 1);
    ramstate = ACCESS; ramload = 32'hDEADBEEF;
    step(); chk("t1_c4_wait", 32'(o_wait[1]), 0); chk("t1_c4_load", o_load[1], 32'hDEADBEEF);
    ren[1] = 0; ramstate = FREE;
    step();

    // 3: ren+wen -> write wins
    ren[3] = 1; wen[3] = 1; addr[3] = 32'h80; store[3] = 32'h12345678; ramstate = BUSY;
    step(); step();
    chk("t3_wen", 32'(o_wen), 1); chk("t3_ren", 32'(o_ren), 0);
    chk("t3_store", o_store, 32'h12345678);
    ramstate = ACCESS; step();
    ren[3] = 0; wen[3] = 0; step();

    // 2: req0 and req2 held, ACCESS always -> 0,2,0,2
    ren[0] = 1; ren[2] = 1; addr[0] = 32'h1000; addr[2] = 32'h2000;
    addr[1] = 32'hAAA0; addr[3] = 32'hBBB0; ramstate = ACCESS;
    for (int c = 0; c < 8; c++) begin
      step();
      if (o_ren) grants.push_back(o_addr == 32'h1000 ? 0 : o_addr == 32'h2000 ? 2 : 9);
    end
    chk("t2_ngrant", grants.size(), 4);
    for (int k = 0; k < grants.size() && k < 4; k++)
      chk($sformatf("t2_grant%0d", k), grants[k], (k % 2) ? 2 : 0);
    ren = '0; step();

    // 4: req3 granted (ptr=3), aborts in 2nd BUSY cycle; req0 next
    ren[3] = 1; ren[0] = 1; addr[3] = 32'h300; ramstate = BUSY;
    step(); step(); chk("t4_g3_addr", o_addr, 32'h300);
    ren[3] = 0; step();
    step(); chk("t4_idle_ren", 32'(o_ren), 0); chk("t4_idle_addr", o_addr, 0);
    step(); chk("t4_g0_addr", o_addr, 32'h1000); chk("t4_g0_ren", 32'(o_ren), 1);
    ramstate = ACCESS; step();
    drain();

    // 5: async reset mid-GRANT
    ren[1] = 1; addr[1] = 32'h40; ramstate = BUSY;
    step(); step();
    chk("t5_pre_ren", 32'(ramREN), 1);
    ramstate = ACCESS; ramload = 32'h55; #1;
    nRST = 0; #1;
    chk("t5_rst_ren", 32'(ramREN), 0);
    chk("t5_rst_load1", req_load[1], 0);
    chk("t5_rst_addr", ramaddr, 0);
    model_reset();
    ren[1] = 0; ramstate = FREE;
    step();
    nRST = 1;
    ren[2] = 1; ren[3] = 1; addr[2] = 32'h2000;
    step(); step(); chk("t5_first_grant", o_addr, 32'h2000);
    drain();

    // 6: LL / SC
    txn(1, 1, 0, 1, 32'h100, 0, saw, ld);
    txn(3, 0, 1, 0, 32'h100, 32'h77, saw, ld);
    txn(1, 0, 1, 1, 32'h100, 32'h99, saw, ld);
    chk("t6a_sc_load", ld, LLSC ? 32'd0 : 32'd1);
    chk("t6a_sc_wen", 32'(saw), LLSC ? 32'd0 : 32'd1);
    txn(1, 1, 0, 1, 32'h100, 0, saw, ld);
    txn(1, 0, 1, 1, 32'h100, 32'h99, saw, ld);
    chk("t6b_sc_load", ld, 32'd1);
    chk("t6b_sc_wen", 32'(saw), 32'd1);
    drain();

    // Randomized phase
    for (int i = 0; i < N; i++) act[i] = 0;
    for (int c = 0; c < 600; c++) begin
      ramstate = ramstate_t'($urandom_range(0, 3));
      ramload = $urandom;
      for (int i = 0; i < N; i++) begin
        if (!act[i] && $urandom_range(0, 2) == 0) begin
          act[i] = 1;
          ren[i] = $urandom_range(0, 1); wen[i] = $urandom_range(0, 1);
          if (!ren[i] && !wen[i]) ren[i] = 1;
          atomic[i] = ($urandom_range(0, 5) == 0);
          addr[i] = 32'h100 + 32'($urandom_range(0, 3)) * 4;
          store[i] = $urandom;
        end
      end
      step();
      for (int i = 0; i < N; i++)
        if (act[i] && (!e_wait[i] || $urandom_range(0, 39) == 0)) begin
          act[i] = 0; ren[i] = 0; wen[i] = 0; atomic[i] = 0;
        end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
